// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: produces {hi,lo} for MULT/MULTU/DIV/DIVU
// and flags a zero divisor.
module md_core
    import md_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  md_op,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, quo, rem;

    always_comb begin
        sgn   = (md_op == OP_MULT) || (md_op == OP_DIV);
        ext_a = {{32{sgn & A[31]}}, A};
        ext_b = {{32{sgn & B[31]}}, B};
        prod  = ext_a * ext_b;

        // Divide on magnitudes so 0x80000000 / -1 needs no special case.
        mag_a    = (sgn && A[31]) ? -A : A;
        mag_b    = (sgn && B[31]) ? -B : B;
        div_zero = (B == '0);
        quo      = div_zero ? '0 : mag_a / mag_b;
        rem      = div_zero ? '0 : mag_a % mag_b;
        if (sgn && (A[31] ^ B[31])) quo = -quo;
        if (sgn && A[31])           rem = -rem;

        result = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? prod : {rem, quo};
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV controller owning HI/LO: latches the result at start,
// holds busy for a fixed latency, then commits.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_t   state, state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0] temp, core_res;
    logic        commit_en, div_zero;
    logic        is_mul, is_div, accept, done;

    md_core u_core (
        .A        (A),
        .B        (B),
        .md_op    (md_op),
        .result   (core_res),
        .div_zero (div_zero)
    );

    assign is_mul    = start && ((md_op == OP_MULT) || (md_op == OP_MULTU));
    assign is_div    = start && ((md_op == OP_DIV)  || (md_op == OP_DIVU));
    assign busy      = (state == BUSY);
    assign stall_req = busy | is_mul | is_div;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (is_mul || is_div) begin
                accept    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (cnt == CW'(1)) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            temp      <= '0;
            commit_en <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (accept) begin
                temp      <= core_res;
                commit_en <= !(is_div && div_zero);
                cnt       <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
                if (done && commit_en) {hi, lo} <= temp;
            end
            // Moves to HI/LO only land while idle; requests during BUSY are dropped.
            if (state == IDLE && start && md_op == OP_MTHI) hi <= A;
            if (state == IDLE && start && md_op == OP_MTLO) lo <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mhi = '0, mlo = '0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {commit, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        u  = '0;
        case (op)
            3'd1: u = sa * sb;
            3'd2: u = {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) return {1'b0, 64'b0};
                q = sa / sb;
                r = sa % sb;
                u = {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {1'b0, 64'b0};
                u = {a % b, a / b};
            end
            default: return {1'b0, 64'b0};
        endcase
        return {1'b1, u};
    endfunction

    task automatic check_state(input string tag, input logic eb);
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, eb});
        chk({tag, "_hi"}, hi, mhi);
        chk({tag, "_lo"}, lo, mlo);
    endtask

    // Called at a negedge; returns at the negedge of cycle N+1.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input logic [2:0] inj_op, input logic [31:0] inj_a);
        int n;
        logic [64:0] r;
        n = (op <= 3'd2) ? MC : DC;
        r = ref_op(op, a, b);
        start = 1'b1; md_op = op; A = a; B = b;
        #1 chk("stall_c0", {31'b0, stall_req}, 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == inj_cyc) begin
                start = 1'b1; md_op = inj_op; A = inj_a; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            check_state("busy_phase", 1'b1);
            chk("stall_busy", {31'b0, stall_req}, 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        if (r[64]) {mhi, mlo} = r[63:0];
        check_state("done", 1'b0);
        #1 chk("stall_done", {31'b0, stall_req}, 32'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; md_op = op; A = a; B = '0;
        #1 chk("stall_mt", {31'b0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        if (op == 3'd5) mhi = a;
        else if (op == 3'd6) mlo = a;
        check_state("mt", 1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; md_op = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check_state("reset", 1'b0);
        chk("reset_stall", {31'b0, stall_req}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, '0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, '0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, '0);
        run_op(3'd4, 32'd7, 32'd2, 0, 3'd0, '0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, '0);
        run_mt(3'd5, 32'h1234_5678);
        run_op(3'd4, 32'd7, 32'd0, 0, 3'd0, '0);
        run_op(3'd3, 32'd9, 32'd0, 0, 3'd0, '0);
        run_mt(3'd6, 32'hCAFE_0001);
        run_mt(3'd0, 32'hDEAD_BEEF);
        run_mt(3'd7, 32'hDEAD_BEEF);
        // Requests while busy must be dropped.
        run_op(3'd1, 32'd1000, 32'hFFFF_FFFD, 3, 3'd6, 32'h0000_AAAA);
        run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 2, 3'd3, 32'd50);
        run_op(3'd4, 32'd100, 32'd9, 10, 3'd5, 32'h5555_5555);

        // Reset mid-divide aborts with no later commit.
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        check_state("rst_abort", 1'b0);
        repeat (DC + 2) @(negedge clk);
        check_state("rst_nocommit", 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if (op >= 3'd5) run_mt(op, a);
            else run_op(op, a, b, ($urandom_range(0, 3) == 0) ? 2 : 0,
                        3'($urandom_range(1, 6)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
